// File: rtl/enc_serial.sv
// Serialising priority encoder: captures a request vector on load and drains
// the index of every set bit, in priority order, over a valid/ready handshake.
module enc_serial #(
    parameter int N         = 8,
    parameter bit PRIO_HIGH = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_vec,
    input  logic         load,
    output logic         busy,
    output logic [W-1:0] idx_out,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W:0]   total,
    output logic         done,
    output logic         zero_err
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W:0]   total_q, total_d;
    logic         done_q, done_d;
    logic         zero_err_q, zero_err_d;

    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_oh;
    logic [W:0]   pop_cnt;
    logic [N-1:0] pending_left;

    // Later matches overwrite earlier ones, so scan direction sets priority.
    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        if (PRIO_HIGH) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (pending_q[i]) begin
                    sel_idx   = W'(i);
                    sel_oh    = '0;
                    sel_oh[i] = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = N; i > 0; i--) begin
                if (pending_q[i-1]) begin
                    sel_idx     = W'(i - 1);
                    sel_oh      = '0;
                    sel_oh[i-1] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_cnt = pop_cnt + {{W{1'b0}}, in_vec[i]};
        end
    end

    assign pending_left = pending_q & ~sel_oh;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        total_d    = total_q;
        done_d     = 1'b0;
        zero_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (|in_vec) begin
                        pending_d = in_vec;
                        total_d   = pop_cnt;
                        state_d   = SCAN;
                    end else begin
                        zero_err_d = 1'b1;
                        total_d    = '0;
                    end
                end
            end
            SCAN: begin
                if (idx_ready) begin
                    pending_d = pending_left;
                    if (pending_left == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            total_q    <= '0;
            done_q     <= 1'b0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            total_q    <= total_d;
            done_q     <= done_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign idx_valid = (state_q == SCAN);
    assign idx_out   = idx_valid ? sel_idx : '0;
    assign total     = total_q;
    assign done      = done_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_enc_serial.sv
// Bench for enc_serial: three instances (N=8 high-first, N=8 low-first, N=5
// high-first) share one stimulus stream and are checked against index lists.
module tb_enc_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       idx_ready = 1'b0;
    logic [7:0] in_vec = '0;

    logic       busy  [3];
    logic       valid [3];
    logic       done  [3];
    logic       zerr  [3];
    logic [2:0] idx   [3];
    logic [3:0] total [3];

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference: per instance, the ordered list of indices still to be emitted.
    int qbuf    [3][8];
    int qhead   [3];
    int qlen    [3];
    int m_total [3];
    bit m_done  [3];
    bit m_zerr  [3];

    always #5 clk = ~clk;

    enc_serial #(.N(8), .PRIO_HIGH(1'b1)) u_hi8 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .load(load),
        .busy(busy[0]), .idx_out(idx[0]), .idx_valid(valid[0]),
        .idx_ready(idx_ready), .total(total[0]), .done(done[0]),
        .zero_err(zerr[0])
    );

    enc_serial #(.N(8), .PRIO_HIGH(1'b0)) u_lo8 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .load(load),
        .busy(busy[1]), .idx_out(idx[1]), .idx_valid(valid[1]),
        .idx_ready(idx_ready), .total(total[1]), .done(done[1]),
        .zero_err(zerr[1])
    );

    enc_serial #(.N(5), .PRIO_HIGH(1'b1)) u_hi5 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec[4:0]), .load(load),
        .busy(busy[2]), .idx_out(idx[2]), .idx_valid(valid[2]),
        .idx_ready(idx_ready), .total(total[2]), .done(done[2]),
        .zero_err(zerr[2])
    );

    function automatic int n_of(int m);
        return (m == 2) ? 5 : 8;
    endfunction

    function automatic bit hi_of(int m);
        return (m != 1);
    endfunction

    task automatic check(string tag, int m, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            qhead[m]   = 0;
            qlen[m]    = 0;
            m_total[m] = 0;
            m_done[m]  = 1'b0;
            m_zerr[m]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int n;
            int v;
            n = n_of(m);
            m_done[m] = 1'b0;
            m_zerr[m] = 1'b0;
            if (qhead[m] < qlen[m]) begin
                if (idx_ready) begin
                    qhead[m]++;
                    if (qhead[m] == qlen[m]) m_done[m] = 1'b1;
                end
            end else if (load) begin
                v = int'(in_vec) & ((1 << n) - 1);
                qhead[m] = 0;
                qlen[m]  = 0;
                if (v == 0) begin
                    m_zerr[m]  = 1'b1;
                    m_total[m] = 0;
                end else begin
                    for (int k = 0; k < n; k++) begin
                        int b;
                        b = hi_of(m) ? (n - 1 - k) : k;
                        if (((v >> b) & 1) == 1) begin
                            qbuf[m][qlen[m]] = b;
                            qlen[m]++;
                        end
                    end
                    m_total[m] = qlen[m];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            bit pend;
            pend = (qhead[m] < qlen[m]);
            check("busy", m, busy[m], pend);
            check("idx_valid", m, valid[m], pend);
            if (pend) begin
                check("idx_out", m, idx[m], qbuf[m][qhead[m]]);
                check("idx_range", m, (int'(idx[m]) < n_of(m)), 1);
            end
            check("total", m, total[m], m_total[m]);
            check("done", m, done[m], m_done[m]);
            check("zero_err", m, zerr[m], m_zerr[m]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();

        // Held in reset with arbitrary inputs: everything stays at zero.
        repeat (4) begin
            in_vec = 8'($urandom);
            load   = 1'($urandom);
            cycle();
            for (int m = 0; m < 3; m++) check("rst_idx", m, idx[m], 0);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Two-bit vector, full-rate drain.
        idx_ready = 1'b1;
        in_vec    = 8'b1000_0001;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        check("first_idx", 0, idx[0], 7);
        check("first_total", 0, total[0], 2);
        cycle();
        check("second_idx", 0, idx[0], 0);
        cycle();
        check("done_pulse", 0, done[0], 1);
        repeat (2) cycle();

        // Backpressure holds the index, then one transfer completes.
        idx_ready = 1'b0;
        in_vec    = 8'b0000_1000;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        repeat (5) begin
            cycle();
            check("bp_hold", 0, idx[0], 3);
        end
        idx_ready = 1'b1;
        repeat (3) cycle();

        // All-zero load, then a load pulse ignored mid-scan.
        in_vec = 8'h00;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        check("zero_err_pulse", 0, zerr[0], 1);
        cycle();
        in_vec = 8'hFF;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        in_vec = 8'h01;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        repeat (10) cycle();

        // Toggling ready, then a back-to-back load in the done cycle.
        in_vec = 8'b0101_0000;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        check("lo_first", 1, idx[1], 4);
        cycle();
        idx_ready = 1'b0;
        cycle();
        idx_ready = 1'b1;
        cycle();
        check("lo_done", 1, done[1], 1);
        in_vec = 8'b0000_0110;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        repeat (4) cycle();

        // Asynchronous reset in the middle of a scan: no done afterwards.
        idx_ready = 1'b0;
        in_vec    = 8'hFF;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            check("async_busy", m, busy[m], 0);
            check("async_valid", m, valid[m], 0);
        end
        model_reset();
        @(negedge clk);
        check_all();
        rst_n     = 1'b1;
        idx_ready = 1'b1;
        repeat (3) cycle();

        // Full five-bit vector on the non-power-of-two instance.
        in_vec = 8'h1F;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        check("n5_total", 2, total[2], 5);
        repeat (6) cycle();

        // Random traffic.
        repeat (400) begin
            in_vec    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            load      = ($urandom_range(0, 2) == 0);
            idx_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        load      = 1'b0;
        idx_ready = 1'b1;
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_serial.md
Name: enc_serial

Overview:
- Parametrised serialising priority encoder; successor to the fixed 4-to-2 combinational encoder.
- Captures an N-bit request vector on a load strobe.
- Emits the index of every set bit, one per accepted transfer, in priority order, over a valid/ready handshake.
- Used wherever several one-hot or multi-hot flags must be turned into a stream of binary indices (interrupt/event drain, request scheduling).

Parameters:
- N, 8, number of request inputs (N >= 2).
- PRIO_HIGH, 1, 1 = highest set index first (classic encoder priority); 0 = lowest set index first.
- W, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vec  in  N  request vector, sampled only on an accepted load.
- load  in  1  capture strobe.
- busy  out  1  high while captured requests remain to be drained.
- idx_out  out  W  index of the current highest-priority pending bit.
- idx_valid  out  1  idx_out is valid.
- idx_ready  in  1  consumer accepts idx_out.
- total  out  W+1  popcount of the vector captured at the last accepted load.
- done  out  1  one-cycle pulse after the last index is accepted.
- zero_err  out  1  one-cycle pulse when a load captures an all-zero vector.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending register=0, total=0; busy, idx_valid, done, zero_err all 0; idx_out=0.
- Reset mid-scan: pending is discarded immediately, with no done pulse.
- State IDLE:
  - load=1 at edge k with in_vec!=0: pending<=in_vec, total<=popcount(in_vec), go to SCAN.
  - load=1 at edge k with in_vec==0: stay IDLE, zero_err=1 for cycle k+1 only, total<=0.
- State SCAN:
  - busy=1 and idx_valid=1.
  - idx_out is the priority index of pending: highest set bit if PRIO_HIGH=1, else lowest. It is derived combinationally from registered pending only, never from in_vec.
- Latency: first index valid in cycle k+1 after the load edge.
- Transfer: idx_valid&&idx_ready at an edge clears that bit in pending.
  - If bits remain, the next index is presented in the following cycle (no bubble; one index per cycle at idx_ready=1).
  - On the last transfer, go to IDLE; done=1 for exactly the next cycle; busy and idx_valid drop in that same cycle.
- Backpressure: with idx_ready=0, idx_out and idx_valid hold stable indefinitely.
- load during SCAN is ignored: no capture, no zero_err, pending unchanged. load in the done cycle (state IDLE) is accepted normally.
- idx_ready while idx_valid=0 has no effect.
- Changes on in_vec outside an accepted load have no effect.
- Widths:
  - total counts up to N, hence W+1 bits.
  - idx_out is a zero-extended binary index.
  - When N is not a power of two, index values >= N never appear.
- done and zero_err are mutually exclusive and each is exactly one cycle wide.

Test Plan:
1. Reset check: hold rst_n=0 with random in_vec/load -> all outputs 0. Assert rst_n=0 asynchronously mid-cycle during SCAN -> busy/idx_valid fall before the next edge; no done pulse afterwards.
2. N=8, PRIO_HIGH=1, idx_ready=1, load in_vec=8'b1000_0001 at edge k:
   - cycle k+1: idx_out=7, idx_valid=1, total=2.
   - cycle k+2: idx_out=0.
   - cycle k+3: done=1, busy=0.
3. Backpressure: load 8'b0000_1000, idx_ready=0 for 5 cycles -> idx_out=3 stable with idx_valid=1 throughout. Raise idx_ready -> one transfer, then done pulse.
4. Zero/ignored loads:
   - load 8'h00 -> zero_err=1 for one cycle, busy stays 0, total=0.
   - During SCAN of 8'hFF, pulse load with 8'h01 -> ignored; exactly 8 indices 7..0 are emitted, then one done.
5. PRIO_HIGH=0 instance, N=8: load 8'b0101_0000 with idx_ready toggling 1,0,1 -> indices 4 then 6, with the hold on the 0 cycle. Back-to-back load in the done cycle is accepted.
6. N=5 (non-power-of-two), PRIO_HIGH=1: load 5'b11111 -> indices 4,3,2,1,0 on consecutive cycles, total=5, idx_out never exceeds 4.
